// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the debounce_sync block.
package debounce_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    PEND_HIGH = 2'd1,
    HIGH      = 2'd2,
    PEND_LOW  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) ff <= '0;
    else                ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw level; optional rise/fall pulses when
// DEBOUNCE_SYNC_EDGE_EN is defined, otherwise rise/fall are tied low.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic raw_in,
  output logic d_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_in;
  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             d_out_n, busy_n;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .d             (raw_in),
    .q             (sync_in)
  );

  // State and stability counter
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: a pending state falls back on any reversal, so a bounce restarts qualification
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      LOW: begin
        if (sync_in) begin
          state_n = PEND_HIGH;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      PEND_HIGH: begin
        if (!sync_in) begin
          state_n = LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sync_in) begin
          state_n = PEND_LOW;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      PEND_LOW: begin
        if (sync_in) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = LOW;
        cnt_n   = '0;
      end
    endcase
    d_out_n = (state_n == HIGH) || (state_n == PEND_LOW);
    busy_n  = (state_n == PEND_HIGH) || (state_n == PEND_LOW);
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      d_out <= 1'b0;
      busy  <= 1'b0;
    end else begin
      d_out <= d_out_n;
      busy  <= busy_n;
    end
  end

`ifdef DEBOUNCE_SYNC_EDGE_EN
  // Pulses coincide with the first cycle d_out shows the new level
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (state == PEND_HIGH) && (state_n == HIGH);
      fall <= (state == PEND_LOW) && (state_n == LOW);
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on raw_in; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized cycles required to accept a level change; legal range 2..65535.
REQ-003 Parameter CNT_W, default $clog2(DEBOUNCE_CYCLES+1), stability counter width; derived, never overridden.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port async_reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 Port raw_in  input  1  asynchronous, possibly bouncing level (switch/pin).
REQ-007 Port d_out  output  1  debounced, clk-synchronous level; drives D of the downstream Dff stage.
REQ-008 Port rise  output  1  one-cycle pulse when d_out goes 0->1.
REQ-009 Port fall  output  1  one-cycle pulse when d_out goes 1->0.
REQ-010 Port busy  output  1  high while a candidate level change is being qualified.

Function
REQ-011 raw_in shall pass through SYNC_STAGES flops; the last stage is sync_in, the only raw-derived signal the FSM uses.
REQ-012 FSM states: LOW, PEND_HIGH, HIGH, PEND_LOW; d_out=0 in LOW/PEND_HIGH, 1 in HIGH/PEND_LOW (registered).
REQ-013 LOW: sync_in=1 -> PEND_HIGH, cnt=1; else stay, cnt=0.
REQ-014 PEND_HIGH: sync_in=0 -> LOW, cnt=0; sync_in=1 and cnt=DEBOUNCE_CYCLES-1 -> HIGH, cnt=0; else cnt+1.
REQ-015 HIGH/PEND_LOW: mirror of REQ-013/014 with polarity inverted.
REQ-016 Latency: raw_in held 1 from first sampling edge E1 -> d_out=1 after edge E(SYNC_STAGES+DEBOUNCE_CYCLES); same for falling.
REQ-017 A synchronized pulse of fewer than DEBOUNCE_CYCLES cycles shall leave d_out, rise, fall unchanged.
REQ-018 rise shall be high exactly the cycle d_out first reads 1; fall exactly the cycle d_out first reads 0; never both.
REQ-019 busy shall be 1 in PEND_HIGH and PEND_LOW, 0 otherwise.
REQ-020 cnt shall never exceed DEBOUNCE_CYCLES-1; no wrap-around possible.
REQ-021 Bounce reversing mid-qualification shall restart counting from zero on the next opposite-level acceptance attempt.

Reset
REQ-022 async_reset_n=0 shall immediately force synchronizer flops=0, state=LOW, cnt=0, d_out=0, rise=0, fall=0, busy=0, independent of clk.
REQ-023 Reset asserted mid-qualification shall abort it with no rise/fall pulse.
REQ-024 After deassertion with raw_in=1, d_out shall rise per REQ-016 latency measured from the first post-reset edge.

Configuration
REQ-025 Macro DEBOUNCE_SYNC_EDGE_EN defined: rise/fall generated per REQ-018.
REQ-026 Macro undefined: rise and fall tied to constant 0, no edge logic synthesized; all other behaviour identical.

Structure
REQ-027 Package debounce_pkg shall hold the FSM state typedef (2-bit enum LOW/PEND_HIGH/HIGH/PEND_LOW) and default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
REQ-028 Sub-module sync_chain (parameter STAGES, ports clk, async_reset_n, d, q) shall implement REQ-011; FSM and counter stay in debounce_sync.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-029 Reset 0 for 20 ns then 1, raw_in=0 -> d_out=0, busy=0, no pulses for 100 ns.
REQ-030 raw_in 0->1 held -> busy=1 from edge 3, d_out=1 and rise=1 after edge 6, rise=0 after edge 7, busy=0.
REQ-031 From HIGH, raw_in=0 for 3 cycles then 1 -> busy pulses, d_out stays 1, fall never asserts.
REQ-032 From HIGH, raw_in 1->0 held -> d_out=0 and fall=1 after 6th edge, single cycle.
REQ-033 raw_in=1, assert async_reset_n low mid-PEND_HIGH (cnt=2) between edges -> outputs 0 immediately; after release d_out=1 six edges later.
REQ-034 Build without DEBOUNCE_SYNC_EDGE_EN, rerun REQ-030/032 -> d_out timing identical, rise=fall=0 throughout.
